fpu_addsub_sequencer: RTL and testbench

Operand-issue and result-capture stage placed directly upstream of the floating-point add/subtract unit in the CORDIC natural-log datapath. It buffers operand pairs in a small FIFO and drives the adder's start/acknowledge handshake one operation at a time. It captures the IEEE result and overflow/underflow flags into a valid/ready output register. A watchdog aborts any operation whose completion never arrives.

---
 rtl/fpu_addsub_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_fpu_addsub_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_addsub_sequencer.sv
// Operand FIFO and start/acknowledge sequencer for the floating-point add/subtract unit.
// Issues one operation at a time, captures the result into a valid/ready register, and aborts
// stuck operations with a watchdog.
module fpu_addsub_sequencer #(
   parameter int unsigned W       = 32,
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_x,
   input  logic [W-1:0] in_y,
   input  logic         in_op,
   input  logic [1:0]   in_rmode,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_result,
   output logic         out_ovf,
   output logic         out_unf,
   output logic         out_timeout,
   output logic         fpu_beg,
   output logic         fpu_ack,
   output logic [W-1:0] fpu_x,
   output logic [W-1:0] fpu_y,
   output logic         fpu_op,
   output logic [1:0]   fpu_rmode,
   input  logic         fpu_ready,
   input  logic [W-1:0] fpu_result,
   input  logic         fpu_ovf,
   input  logic         fpu_unf,
   output logic         busy
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned EW = 2 * W + 3;
   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      StFlush,
      StIdle,
      StStart,
      StWait,
      StAck
   } state_e;

   state_e state_q, state_d;

   logic [EW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wptr_q, rptr_q;
   logic [CW-1:0] count_q;
   logic [EW-1:0] opnd_q;
   logic [TW-1:0] wdog_q, wdog_d;

   logic         out_valid_q, out_valid_d;
   logic [W-1:0] out_result_q, out_result_d;
   logic         out_ovf_q, out_ovf_d;
   logic         out_unf_q, out_unf_d;
   logic         out_timeout_q, out_timeout_d;

   logic push, pop, cap_ready, cap_timeout;

   assign in_ready = (count_q != CW'(DEPTH));
   assign push     = in_valid & in_ready;

   // ---------------------------------------------------------------------------------------------
   // Operand FIFO: entry is {op, rmode, x, y}
   // ---------------------------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wptr_q] <= {in_op, in_rmode, in_x, in_y};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         opnd_q  <= '0;
      end else begin
         if (push) begin
            wptr_q <= wptr_q + AW'(1);
         end
         if (pop) begin
            rptr_q <= rptr_q + AW'(1);
            opnd_q <= mem_q[rptr_q];
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   assign fpu_op    = opnd_q[EW-1];
   assign fpu_rmode = opnd_q[EW-2 -: 2];
   assign fpu_x     = opnd_q[2*W-1 -: W];
   assign fpu_y     = opnd_q[W-1:0];

   // ---------------------------------------------------------------------------------------------
   // Sequencer FSM
   // ---------------------------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StFlush;
         wdog_q  <= '0;
      end else begin
         state_q <= state_d;
         wdog_q  <= wdog_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      wdog_d      = wdog_q;
      pop         = 1'b0;
      cap_ready   = 1'b0;
      cap_timeout = 1'b0;
      case (state_q)
         // Acks any adder left in its done state by a mid-operation reset.
         StFlush: state_d = StIdle;
         StIdle: begin
            // Holding off while the result register is full keeps it from being overwritten.
            if ((count_q != '0) && !out_valid_q) begin
               pop     = 1'b1;
               state_d = StStart;
            end
         end
         StStart: begin
            wdog_d  = '0;
            state_d = StWait;
         end
         StWait: begin
            wdog_d = wdog_q + TW'(1);
            if (fpu_ready) begin
               cap_ready = 1'b1;
               state_d   = StAck;
            end else if (wdog_q == TW'(TIMEOUT - 1)) begin
               cap_timeout = 1'b1;
               state_d     = StAck;
            end
         end
         StAck:   state_d = StIdle;
         default: state_d = StFlush;
      endcase
   end

   assign fpu_beg = (state_q == StStart);
   assign fpu_ack = (state_q == StFlush) || (state_q == StAck);
   assign busy    = (state_q != StIdle) || (count_q != '0);

   // ---------------------------------------------------------------------------------------------
   // Result register
   // ---------------------------------------------------------------------------------------------
   always_comb begin
      out_valid_d   = out_valid_q & ~out_ready;
      out_result_d  = out_result_q;
      out_ovf_d     = out_ovf_q;
      out_unf_d     = out_unf_q;
      out_timeout_d = out_timeout_q;
      if (cap_ready) begin
         out_valid_d   = 1'b1;
         out_result_d  = fpu_result;
         out_ovf_d     = fpu_ovf;
         out_unf_d     = fpu_unf;
         out_timeout_d = 1'b0;
      end else if (cap_timeout) begin
         out_valid_d   = 1'b1;
         out_result_d  = '0;
         out_ovf_d     = 1'b0;
         out_unf_d     = 1'b0;
         out_timeout_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid_q   <= 1'b0;
         out_result_q  <= '0;
         out_ovf_q     <= 1'b0;
         out_unf_q     <= 1'b0;
         out_timeout_q <= 1'b0;
      end else begin
         out_valid_q   <= out_valid_d;
         out_result_q  <= out_result_d;
         out_ovf_q     <= out_ovf_d;
         out_unf_q     <= out_unf_d;
         out_timeout_q <= out_timeout_d;
      end
   end

   assign out_valid   = out_valid_q;
   assign out_result  = out_result_q;
   assign out_ovf     = out_ovf_q;
   assign out_unf     = out_unf_q;
   assign out_timeout = out_timeout_q;

endmodule

// File: tb/tb_fpu_addsub_sequencer.sv
// Scoreboard bench for fpu_addsub_sequencer: a scripted adder model answers each start pulse,
// a monitor compares every accepted result against the queue of hand-computed expectations.
module tb_fpu_addsub_sequencer;

   localparam int W       = 32;
   localparam int TIMEOUT = 64;

   typedef struct {
      logic [31:0] x;
      logic [31:0] y;
      logic        op;
      logic [1:0]  rm;
      int          lat;   // ready in this WAIT cycle; 0 = never
      logic [31:0] res;
      logic        ovf;
      logic        unf;
      bit          chk;   // check ack timing
   } plan_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid, in_ready, in_op;
   logic [W-1:0]  in_x, in_y;
   logic [1:0]    in_rmode;
   logic          out_valid, out_ready, out_ovf, out_unf, out_timeout;
   logic [W-1:0]  out_result;
   logic          fpu_beg, fpu_ack, fpu_op, fpu_ready, fpu_ovf, fpu_unf, busy;
   logic [W-1:0]  fpu_x, fpu_y, fpu_result;
   logic [1:0]    fpu_rmode;

   plan_t         plan_q[$];
   logic [34:0]   exp_q[$];
   plan_t         cur;
   logic [34:0]   mon_exp;
   int            n_checks = 0;
   int            n_fail   = 0;

   fpu_addsub_sequencer #(
      .W      (W),
      .DEPTH  (4),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_x       (in_x),
      .in_y       (in_y),
      .in_op      (in_op),
      .in_rmode   (in_rmode),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_ovf    (out_ovf),
      .out_unf    (out_unf),
      .out_timeout(out_timeout),
      .fpu_beg    (fpu_beg),
      .fpu_ack    (fpu_ack),
      .fpu_x      (fpu_x),
      .fpu_y      (fpu_y),
      .fpu_op     (fpu_op),
      .fpu_rmode  (fpu_rmode),
      .fpu_ready  (fpu_ready),
      .fpu_result (fpu_result),
      .fpu_ovf    (fpu_ovf),
      .fpu_unf    (fpu_unf),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Monitor: a transfer happens at the next rising edge when valid & ready at the falling edge.
   always @(negedge clk) begin
      if (rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_result: got 0x%0h, expected none", out_result);
         end else begin
            mon_exp = exp_q.pop_front();
            check("result{res,ovf,unf,to}", {out_result, out_ovf, out_unf, out_timeout}, mon_exp);
         end
      end
   end

   // Adder model: follows the plan queue, one operation per start pulse.
   initial begin
      fpu_ready  = 1'b0;
      fpu_result = '0;
      fpu_ovf    = 1'b0;
      fpu_unf    = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (fpu_beg) begin
            if (plan_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL adder_plan: got fpu_beg, expected no operation");
            end else begin
               cur = plan_q.pop_front();
               check("fpu_x", fpu_x, cur.x);
               check("fpu_y", fpu_y, cur.y);
               check("fpu_op_rmode", {fpu_op, fpu_rmode}, {cur.op, cur.rm});
               if (cur.lat > 0) begin
                  repeat (cur.lat) @(posedge clk);
                  #1;
                  fpu_ready  = 1'b1;
                  fpu_result = cur.res;
                  fpu_ovf    = cur.ovf;
                  fpu_unf    = cur.unf;
                  @(posedge clk);
                  #1;
                  check("ack_after_ready", {fpu_ack, out_valid}, 2'b11);
                  fpu_ready = 1'b0;
                  @(posedge clk);
                  #1;
                  check("ack_one_cycle", fpu_ack, 1'b0);
               end else begin
                  int k;
                  k = 0;
                  while (!fpu_ack && k < 300) begin
                     @(posedge clk);
                     #1;
                     k++;
                  end
                  if (cur.chk) begin
                     check("timeout_ack_cycle", k, TIMEOUT + 1);
                     @(posedge clk);
                     #1;
                     check("timeout_ack_one_cycle", fpu_ack, 1'b0);
                  end
               end
            end
         end
      end
   end

   task automatic push(input logic [31:0] x, input logic [31:0] y, input logic op,
                       input logic [1:0] rm);
      bit done;
      done     = 1'b0;
      in_valid = 1'b1;
      in_x     = x;
      in_y     = y;
      in_op    = op;
      in_rmode = rm;
      for (int i = 0; i < 300 && !done; i++) begin
         @(negedge clk);
         if (in_ready) done = 1'b1;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!done) begin
         n_checks++;
         n_fail++;
         $display("FAIL push_accept: got in_ready=0 for 300 cycles, expected 1");
      end
   endtask

   task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic op,
                        input logic [1:0] rm, input int lat, input logic [31:0] res,
                        input logic ovf, input logic unf);
      plan_t p;
      p.x   = x;
      p.y   = y;
      p.op  = op;
      p.rm  = rm;
      p.lat = lat;
      p.res = res;
      p.ovf = ovf;
      p.unf = unf;
      p.chk = 1'b1;
      plan_q.push_back(p);
      if (lat > 0) exp_q.push_back({res, ovf, unf, 1'b0});
      else         exp_q.push_back({32'h0, 1'b0, 1'b0, 1'b1});
      push(x, y, op, rm);
   endtask

   task automatic wait_drain(input string name);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 500 && !ok; i++) begin
         @(posedge clk);
         #1;
         ok = (exp_q.size() == 0) && (plan_q.size() == 0) && !busy && !out_valid;
      end
      check(name, ok, 1'b1);
   endtask

   initial begin
      int nb;
      rst       = 1'b0;
      in_valid  = 1'b0;
      in_x      = '0;
      in_y      = '0;
      in_op     = 1'b0;
      in_rmode  = 2'b00;
      out_ready = 1'b1;
      #3;
      check("rst_ack_beg", {fpu_ack, fpu_beg}, 2'b10);
      check("rst_in_ready_busy", {in_ready, busy}, 2'b11);
      check("rst_out", {out_valid, out_result, out_ovf, out_unf, out_timeout}, '0);
      check("rst_fpu_opnd", {fpu_x, fpu_y, fpu_op, fpu_rmode}, '0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("flush_ack", fpu_ack, 1'b1);
      @(posedge clk);
      #1;
      check("idle_after_flush", {fpu_ack, busy}, 2'b00);

      // Single add 1.0 + 2.0 = 3.0, ready 10 cycles after beg
      issue(32'h3F800000, 32'h40000000, 1'b0, 2'b00, 10, 32'h40400000, 1'b0, 1'b0);
      check("beg_t1", fpu_beg, 1'b0);
      @(posedge clk);
      #1;
      check("beg_t2", fpu_beg, 1'b1);
      @(posedge clk);
      #1;
      check("beg_t3", fpu_beg, 1'b0);
      wait_drain("drain_single");

      // FIFO full with the output stalled
      out_ready = 1'b0;
      issue(32'h3F800000, 32'h3F800000, 1'b0, 2'b01, 3, 32'h40000000, 1'b0, 1'b0);
      issue(32'h40000000, 32'h3F800000, 1'b1, 2'b10, 3, 32'h3F800000, 1'b0, 1'b0);
      issue(32'h40400000, 32'h3F800000, 1'b0, 2'b11, 3, 32'h40800000, 1'b0, 1'b0);
      issue(32'h00800001, 32'h00800000, 1'b1, 2'b00, 3, 32'h00000001, 1'b0, 1'b1);
      issue(32'h3F000000, 32'h3E800000, 1'b0, 2'b01, 3, 32'h3F400000, 1'b0, 1'b0);
      check("in_ready_full", in_ready, 1'b0);
      nb = 0;
      repeat (20) begin
         @(posedge clk);
         #1;
         if (fpu_beg) nb++;
      end
      check("no_beg_while_stalled", nb, 0);
      check("out_valid_held", out_valid, 1'b1);
      out_ready = 1'b1;
      wait_drain("drain_full");

      // Push lands in the IDLE pop cycle
      issue(32'h40800000, 32'h40400000, 1'b1, 2'b10, 2, 32'h3F800000, 1'b0, 1'b0);
      issue(32'h3F800000, 32'h40800000, 1'b0, 2'b11, 2, 32'h40A00000, 1'b0, 1'b0);
      check("in_ready_after_pushpop", in_ready, 1'b1);
      wait_drain("drain_pushpop");

      // Watchdog abort, then a normal operation
      issue(32'h40000000, 32'h40000000, 1'b0, 2'b00, 0, 32'h0, 1'b0, 1'b0);
      issue(32'h40000000, 32'h40000000, 1'b0, 2'b01, 5, 32'h40800000, 1'b0, 1'b0);
      wait_drain("drain_timeout");

      // Ready and timeout in the same cycle: ready wins
      issue(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 2'b00, TIMEOUT, 32'h7F800000, 1'b1, 1'b0);
      wait_drain("drain_tie");

      // Reset in WAIT with three pairs queued
      cur.x   = 32'h11111111;
      cur.y   = 32'h22222222;
      cur.op  = 1'b0;
      cur.rm  = 2'b00;
      cur.lat = 0;
      cur.res = '0;
      cur.ovf = 1'b0;
      cur.unf = 1'b0;
      cur.chk = 1'b0;
      plan_q.push_back(cur);
      push(32'h11111111, 32'h22222222, 1'b0, 2'b00);
      push(32'h33333333, 32'h44444444, 1'b1, 2'b01);
      push(32'h55555555, 32'h66666666, 1'b0, 2'b10);
      push(32'h77777777, 32'h88888888, 1'b1, 2'b11);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("midrst_ack", fpu_ack, 1'b1);
      check("midrst_state", {out_valid, in_ready, busy}, 3'b011);
      @(posedge clk);
      #1;
      check("midrst_ack_hold", fpu_ack, 1'b1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("midrst_flush", {fpu_ack, busy}, 2'b11);
      @(posedge clk);
      #1;
      check("midrst_idle", {fpu_ack, busy, in_ready, out_valid}, 4'b0010);
      repeat (10) @(posedge clk);
      #1;
      check("queues_empty", exp_q.size() + plan_q.size(), 0);
      check("no_stray_activity", {busy, out_valid, fpu_beg}, 3'b000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
